// File: rtl/jtag_tdo_axis.sv
// TDO return path: captures the shifter's 32-bit TDO word on each DONE rising edge,
// buffers it in a first-word-fall-through FIFO and streams it out as AXI4-Stream packets.
module jtag_tdo_axis #(
  parameter int C_M_AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH          = 16
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           DONE,
  input  logic [31:0]                    TDO_VECTOR,
  input  logic [15:0]                    PKT_LEN,
  output logic                           M_AXIS_TVALID,
  input  logic                           M_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                           M_AXIS_TLAST,
  output logic                           OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]    LEVEL
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Each entry is {tlast, tdo}, so framing is fixed at push time.
  logic [32:0] mem [FIFO_DEPTH];

  logic        done_q, done_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic        overflow_q, overflow_d;
  logic [31:0] hold_q, hold_d;

  logic        cap;
  logic        empty;
  logic        full;
  logic        pop;
  logic        last;
  logic        push_ok;
  logic [32:0] head;

  always_comb begin
    head  = mem[rd_ptr_q[AW-1:0]];
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    cap   = DONE & ~done_q;
    pop   = ~empty & M_AXIS_TREADY;
    last  = (PKT_LEN <= 16'd1) || (pkt_cnt_q == PKT_LEN - 16'd1);
    // A full FIFO still accepts the capture when the head leaves in the same cycle.
    push_ok = cap & (~full | pop);

    done_d     = DONE;
    wr_ptr_d   = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (push_ok) begin
      pkt_cnt_d = last ? 16'd0 : pkt_cnt_q + 16'd1;
    end
    overflow_d = overflow_q | (cap & ~push_ok);
    hold_d     = empty ? hold_q : head[31:0];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      overflow_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      overflow_q <= overflow_d;
      hold_q     <= hold_d;
      if (push_ok) begin
        mem[wr_ptr_q[AW-1:0]] <= {last, TDO_VECTOR};
      end
    end
  end

  // hold_q keeps TDATA at the last presented word once the FIFO drains.
  always_comb begin
    M_AXIS_TDATA       = '0;
    M_AXIS_TDATA[31:0] = empty ? hold_q : head[31:0];
  end

  assign M_AXIS_TVALID = ~empty;
  assign M_AXIS_TLAST  = ~empty & head[32];
  assign OVERFLOW      = overflow_q;
  assign LEVEL         = wr_ptr_q - rd_ptr_q;

endmodule
